// File: rtl/vpu_pkg.sv
// Shared vector-unit definitions: default vector geometry, the register-select
// width used by the vector register file, and the load-unit state encoding.
// Imported by the vector load unit. The vector RF and the store path see the
// same constants.
package vpu_pkg;

    localparam int VEC_WIDTH  = 16;   // lane width in bits and lane count
    localparam int VEC_ADDR_W = 16;   // scalar memory address width
    localparam int VREG_SEL_W = 5;    // vector register select width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } vld_state_t;

endpackage

// File: rtl/vector_load_unit.sv
// vector_load_unit
//   Fills one vector register from scalar-wide memory. It issues WIDTH
//   sequential single-lane reads at base_addr + i*stride and stores lane i at
//   WD[i]. It then drives one full-vector write into the vector RF write port.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start; base/stride/vd latched when start=1
//   REQ   | mem_req=1 for exactly one cycle with mem_addr of current lane
//   WAIT  | holding for mem_rvalid; captures the lane into the buffer
//   WRITE | WEV=done=1, RD/WD driven for one cycle, then back to IDLE
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   start                begin a load (honoured only in IDLE)
//   base_addr, stride    lane-0 address and per-lane address step
//   vd                   destination vector register
//   mem_req, mem_addr    one-cycle read request and its address
//   mem_rvalid, mem_rdata read response (ignored outside WAIT)
//   WEV, RD, WD          RF write enable pulse, destination, full vector data
//   busy                 high in every state except IDLE
//   done                 one-cycle pulse coincident with WEV
module vector_load_unit
    import vpu_pkg::*;
#(
    parameter int WIDTH  = VEC_WIDTH,
    parameter int ADDR_W = VEC_ADDR_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [ADDR_W-1:0]                base_addr,
    input  logic [ADDR_W-1:0]                stride,
    input  logic [VREG_SEL_W-1:0]            vd,
    output logic                             mem_req,
    output logic [ADDR_W-1:0]                mem_addr,
    input  logic                             mem_rvalid,
    input  logic [WIDTH-1:0]                 mem_rdata,
    output logic                             WEV,
    output logic [VREG_SEL_W-1:0]            RD,
    output logic [WIDTH-1:0][WIDTH-1:0]      WD,
    output logic                             busy,
    output logic                             done
);

    localparam int                LANE_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WIDTH - 1);

    vld_state_t                   state;
    logic [LANE_W-1:0]            lane;
    logic [ADDR_W-1:0]            stride_q;
    logic [VREG_SEL_W-1:0]        vd_q;
    logic [WIDTH-1:0][WIDTH-1:0]  lane_buf;
    logic [WIDTH-1:0][WIDTH-1:0]  lane_buf_next;

    // The last lane arrives in the same cycle WD is loaded. WD therefore takes
    // the buffer with that lane merged in, and no extra cycle is spent
    // copying it.
    always_comb begin
        lane_buf_next       = lane_buf;
        lane_buf_next[lane] = mem_rdata;
    end

    // mem_addr doubles as the running lane address. It only advances when
    // the next request is issued, so it is valid whenever mem_req is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lane     <= '0;
            stride_q <= '0;
            vd_q     <= '0;
            lane_buf <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            WEV      <= 1'b0;
            RD       <= '0;
            WD       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            mem_req <= 1'b0;
            WEV     <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        stride_q <= stride;
                        vd_q     <= vd;
                        lane     <= '0;
                        mem_addr <= base_addr;
                        mem_req  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        lane_buf[lane] <= mem_rdata;
                        if (lane == LAST_LANE) begin
                            WEV   <= 1'b1;
                            done  <= 1'b1;
                            RD    <= vd_q;
                            WD    <= lane_buf_next;
                            state <= WRITE;
                        end else begin
                            lane     <= lane + 1'b1;
                            mem_addr <= mem_addr + stride_q;  // wraps modulo 2^ADDR_W
                            mem_req  <= 1'b1;
                            state    <= REQ;
                        end
                    end
                end
                WRITE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
